weight_stream_reader: RTL and testbench

- Read-side master for the 4-port weight RAM (combinational read, sync write). It owns all four address ports and emits weight words as a 4-lane valid/ready stream into the compute datapath.
- On a start command it sweeps a contiguous word range [base, base+len), four consecutive words per beat.
- It marks partial tail beats with a lane-keep mask and signals completion with a done pulse.
- Write enables are driven low; this block never writes the RAM.

---
 rtl/weight_stream_pkg.sv | 22 ++
 rtl/stream_out_reg.sv | 59 +++++
 rtl/weight_stream_reader.sv | 169 ++++++++++++++++
 tb/tb_weight_stream_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_pkg.sv
// Shared types and helpers for the weight RAM read streamer.
package weight_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int LANES = 4;

    // Lanes below min(rem, LANES) carry valid words; bit0 is lane a.
    function automatic logic [LANES-1:0] keep_from_rem(input logic [31:0] rem);
        logic [LANES-1:0] keep;
        keep = '0;
        for (int i = 0; i < LANES; i++) begin
            if (rem > unsigned'(i)) keep[i] = 1'b1;
        end
        return keep;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register; holds its beat until accepted.
module stream_out_reg #(
    parameter int DW = 128,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] in_data,
    input  logic [KW-1:0] in_keep,
    input  logic          in_last,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [KW-1:0] out_keep,
    output logic          out_last
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [KW-1:0] keep_q, keep_d;
    logic          last_q, last_d;

    // The owner only raises load when the slot is empty or being drained.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            keep_d  = in_keep;
            last_d  = in_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;

endmodule

// File: rtl/weight_stream_reader.sv
// Sweeps a contiguous range of the 4-port weight RAM and streams it out
// four words per beat, with a keep mask on the tail beat.
//
//   state | meaning
//   IDLE  | waiting for start; validates command, pulses err/done for trivial cases
//   RUN   | driving lane addresses, loading one beat per free output slot
//   FLUSH | last beat loaded, waiting for it to be accepted
module weight_stream_reader
    import weight_stream_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 48,
    parameter int AW     = $clog2(HEIGHT),
    parameter int LW     = $clog2(HEIGHT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AW-1:0]          base_addr,
    input  logic [LW-1:0]          len,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [AW-1:0]          ram_addr_a,
    output logic [AW-1:0]          ram_addr_b,
    output logic [AW-1:0]          ram_addr_c,
    output logic [AW-1:0]          ram_addr_d,
    output logic                   ram_we_a,
    output logic                   ram_we_b,
    output logic                   ram_we_c,
    output logic                   ram_we_d,
    input  logic [WIDTH-1:0]       ram_q_a,
    input  logic [WIDTH-1:0]       ram_q_b,
    input  logic [WIDTH-1:0]       ram_q_c,
    input  logic [WIDTH-1:0]       ram_q_d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_last
);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [LW:0]              end_sum;
    logic [LW-1:0]            take;
    logic                     is_last;
    logic                     load;
    logic [AW-1:0]            lane_addr [LANES];
    logic [WIDTH-1:0]         lane_q    [LANES];
    logic [LANES-1:0]         beat_keep;
    logic [LANES*WIDTH-1:0]   beat_data;

    assign end_sum   = (LW+1)'(base_addr) + (LW+1)'(len);
    assign take      = (rem_q >= LW'(LANES)) ? LW'(LANES) : rem_q;
    assign is_last   = (rem_q <= LW'(LANES));
    assign beat_keep = keep_from_rem(32'(rem_q));

    assign lane_q[0] = ram_q_a;
    assign lane_q[1] = ram_q_b;
    assign lane_q[2] = ram_q_c;
    assign lane_q[3] = ram_q_d;

    // Lanes past the tail are parked on ptr so no port ever leaves the RAM.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_addr[i] = '0;
            if (state_q == RUN) begin
                lane_addr[i] = (rem_q > LW'(i)) ? ptr_q + AW'(i) : ptr_q;
            end
        end
    end

    always_comb begin
        beat_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (beat_keep[i]) beat_data[i*WIDTH +: WIDTH] = lane_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (end_sum > (LW+1)'(HEIGHT)) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        ptr_d   = base_addr;
                        rem_d   = len;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!out_valid || out_ready) begin
                    load  = 1'b1;
                    ptr_d = ptr_q + AW'(LANES);
                    rem_d = rem_q - take;
                    if (is_last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (out_valid && out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    stream_out_reg #(
        .DW (LANES*WIDTH),
        .KW (LANES)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .in_data   (beat_data),
        .in_keep   (beat_keep),
        .in_last   (is_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign ram_addr_a = lane_addr[0];
    assign ram_addr_b = lane_addr[1];
    assign ram_addr_c = lane_addr[2];
    assign ram_addr_d = lane_addr[3];
    assign ram_we_a   = 1'b0;
    assign ram_we_b   = 1'b0;
    assign ram_we_c   = 1'b0;
    assign ram_we_d   = 1'b0;

endmodule

// File: tb/tb_weight_stream_reader.sv
// Directed bench for weight_stream_reader against a ram[i] = i model.
module tb_weight_stream_reader;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 48;
    localparam int AW     = 6;
    localparam int LW     = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [LW-1:0]    len;
    logic             busy, done, err;
    logic [AW-1:0]    ram_addr_a, ram_addr_b, ram_addr_c, ram_addr_d;
    logic             ram_we_a, ram_we_b, ram_we_c, ram_we_d;
    logic [WIDTH-1:0] ram_q_a, ram_q_b, ram_q_c, ram_q_d;
    logic             out_valid, out_ready;
    logic [127:0]     out_data;
    logic [3:0]       out_keep;
    logic             out_last;

    logic [WIDTH-1:0] mem [HEIGHT];

    assign ram_q_a = mem[ram_addr_a];
    assign ram_q_b = mem[ram_addr_b];
    assign ram_q_c = mem[ram_addr_c];
    assign ram_q_d = mem[ram_addr_d];

    always #5 clk = ~clk;

    weight_stream_reader #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_addr_c (ram_addr_c),
        .ram_addr_d (ram_addr_d),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_we_c   (ram_we_c),
        .ram_we_d   (ram_we_d),
        .ram_q_a    (ram_q_a),
        .ram_q_b    (ram_q_b),
        .ram_q_c    (ram_q_c),
        .ram_q_d    (ram_q_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] beat4(input int a, input int b, input int c, input int d);
        return {d[31:0], c[31:0], b[31:0], a[31:0]};
    endfunction

    // Results of the most recent command.
    logic [127:0] bd [8];
    logic [3:0]   bk [8];
    logic         bl [8];
    int           nb, n_done, n_err, first_v, done_c, err_c, max_addr;
    logic         busy_seen;

    // Cycle 0 is the cycle start is high; ready follows pat for cycles 1..pat_n, then stays 1.
    // dup_cyc > 0 re-pulses start (base 0, len 4) in that cycle.
    task automatic run_cmd(input int b, input int l, input logic [15:0] pat, input int pat_n,
                           input int n_cyc, input int dup_cyc);
        logic         pv, pr, pl;
        logic [127:0] pd;
        logic [3:0]   pk;
        logic [23:0]  pa;
        nb = 0; n_done = 0; n_err = 0; first_v = -1; done_c = -1; err_c = -1;
        max_addr = 0; busy_seen = 1'b0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pk = '0; pa = '0;
        @(negedge clk);
        base_addr = AW'(b); len = LW'(l); start = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= n_cyc; c++) begin
            @(negedge clk);
            start = (c == dup_cyc);
            if (c == dup_cyc) begin
                base_addr = '0;
                len       = LW'(4);
            end
            out_ready = (c - 1 < pat_n) ? pat[(c-1) & 15] : 1'b1;
            if (busy) busy_seen = 1'b1;
            if (done) begin n_done++; done_c = c; end
            if (err)  begin n_err++;  err_c  = c; end
            if (out_valid && first_v < 0) first_v = c;
            if (int'(ram_addr_a) > max_addr) max_addr = int'(ram_addr_a);
            if (int'(ram_addr_b) > max_addr) max_addr = int'(ram_addr_b);
            if (int'(ram_addr_c) > max_addr) max_addr = int'(ram_addr_c);
            if (int'(ram_addr_d) > max_addr) max_addr = int'(ram_addr_d);
            if (pv && !pr) begin
                expect_eq("stall_valid", out_valid, 1'b1);
                expect_eq("stall_data", out_data, pd);
                expect_eq("stall_keep", out_keep, pk);
                expect_eq("stall_last", out_last, pl);
                expect_eq("stall_addr", {ram_addr_d, ram_addr_c, ram_addr_b, ram_addr_a}, pa);
            end
            if (out_valid && out_ready && nb < 8) begin
                bd[nb] = out_data;
                bk[nb] = out_keep;
                bl[nb] = out_last;
                nb++;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pk = out_keep; pl = out_last;
            pa = {ram_addr_d, ram_addr_c, ram_addr_b, ram_addr_a};
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int rst_done;
        for (int i = 0; i < HEIGHT; i++) mem[i] = WIDTH'(i);
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        expect_eq("rst_busy", busy, 1'b0);
        expect_eq("rst_done", done, 1'b0);
        expect_eq("rst_err", err, 1'b0);
        expect_eq("rst_valid", out_valid, 1'b0);
        expect_eq("rst_last", out_last, 1'b0);
        expect_eq("rst_keep", out_keep, 4'h0);
        expect_eq("rst_data", out_data, 128'h0);
        expect_eq("rst_addr", {ram_addr_d, ram_addr_c, ram_addr_b, ram_addr_a}, 24'h0);
        expect_eq("rst_we", {ram_we_d, ram_we_c, ram_we_b, ram_we_a}, 4'h0);
        rst = 1'b0;

        // base 0 len 8, continuous ready
        run_cmd(0, 8, 16'h0, 0, 8, -1);
        expect_eq("t1_nbeats", nb, 2);
        expect_eq("t1_b0_data", bd[0], beat4(0, 1, 2, 3));
        expect_eq("t1_b0_keep", bk[0], 4'hf);
        expect_eq("t1_b0_last", bl[0], 1'b0);
        expect_eq("t1_b1_data", bd[1], beat4(4, 5, 6, 7));
        expect_eq("t1_b1_keep", bk[1], 4'hf);
        expect_eq("t1_b1_last", bl[1], 1'b1);
        expect_eq("t1_first_valid", first_v, 2);
        expect_eq("t1_done_cyc", done_c, 4);
        expect_eq("t1_ndone", n_done, 1);
        expect_eq("t1_busy", busy_seen, 1'b1);
        expect_eq("t1_max_addr", max_addr, 7);

        // tail beat near the top of the RAM
        run_cmd(40, 6, 16'h0, 0, 8, -1);
        expect_eq("t2_nbeats", nb, 2);
        expect_eq("t2_b0_data", bd[0], beat4(40, 41, 42, 43));
        expect_eq("t2_b0_keep", bk[0], 4'hf);
        expect_eq("t2_b0_last", bl[0], 1'b0);
        expect_eq("t2_b1_data", bd[1], beat4(44, 45, 0, 0));
        expect_eq("t2_b1_keep", bk[1], 4'h3);
        expect_eq("t2_b1_last", bl[1], 1'b1);
        expect_eq("t2_max_addr", max_addr, 45);
        expect_eq("t2_ndone", n_done, 1);

        // out of range: 45 + 4 = 49 > 48
        run_cmd(45, 4, 16'h0, 0, 5, -1);
        expect_eq("t3_nerr", n_err, 1);
        expect_eq("t3_err_cyc", err_c, 1);
        expect_eq("t3_nbeats", nb, 0);
        expect_eq("t3_valid_seen", first_v, -1);
        expect_eq("t3_busy", busy_seen, 1'b0);
        expect_eq("t3_ndone", n_done, 0);

        // zero length
        run_cmd(0, 0, 16'h0, 0, 5, -1);
        expect_eq("t3z_ndone", n_done, 1);
        expect_eq("t3z_done_cyc", done_c, 1);
        expect_eq("t3z_nbeats", nb, 0);
        expect_eq("t3z_busy", busy_seen, 1'b0);
        expect_eq("t3z_nerr", n_err, 0);

        // exact fit: 44 + 4 = 48
        run_cmd(44, 4, 16'h0, 0, 6, -1);
        expect_eq("t3e_nerr", n_err, 0);
        expect_eq("t3e_nbeats", nb, 1);
        expect_eq("t3e_b0_data", bd[0], beat4(44, 45, 46, 47));
        expect_eq("t3e_b0_keep", bk[0], 4'hf);
        expect_eq("t3e_b0_last", bl[0], 1'b1);
        expect_eq("t3e_max_addr", max_addr, 47);

        // backpressure 1,0,0,1,0,1
        run_cmd(8, 12, 16'h0029, 6, 12, -1);
        expect_eq("t4_nbeats", nb, 3);
        expect_eq("t4_b0_data", bd[0], beat4(8, 9, 10, 11));
        expect_eq("t4_b1_data", bd[1], beat4(12, 13, 14, 15));
        expect_eq("t4_b2_data", bd[2], beat4(16, 17, 18, 19));
        expect_eq("t4_b0_last", bl[0], 1'b0);
        expect_eq("t4_b1_last", bl[1], 1'b0);
        expect_eq("t4_b2_last", bl[2], 1'b1);
        expect_eq("t4_done_cyc", done_c, 8);
        expect_eq("t4_ndone", n_done, 1);

        // reset in RUN after the first beat is presented
        @(negedge clk);
        base_addr = '0; len = LW'(12); start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        expect_eq("t5_pre_valid", out_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        expect_eq("t5_valid", out_valid, 1'b0);
        expect_eq("t5_busy", busy, 1'b0);
        expect_eq("t5_done", done, 1'b0);
        rst = 1'b0;
        rst_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || err || out_valid) rst_done++;
        end
        expect_eq("t5_quiet", rst_done, 0);
        run_cmd(4, 4, 16'h0, 0, 6, -1);
        expect_eq("t5_nbeats", nb, 1);
        expect_eq("t5_b0_data", bd[0], beat4(4, 5, 6, 7));
        expect_eq("t5_b0_keep", bk[0], 4'hf);
        expect_eq("t5_b0_last", bl[0], 1'b1);
        expect_eq("t5_ndone", n_done, 1);

        // start while busy is ignored
        run_cmd(8, 8, 16'h0, 0, 10, 2);
        expect_eq("t6_nbeats", nb, 2);
        expect_eq("t6_b0_data", bd[0], beat4(8, 9, 10, 11));
        expect_eq("t6_b1_data", bd[1], beat4(12, 13, 14, 15));
        expect_eq("t6_b1_last", bl[1], 1'b1);
        expect_eq("t6_ndone", n_done, 1);
        expect_eq("t6_done_cyc", done_c, 4);
        expect_eq("t6_nerr", n_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
